immediate_encoder: RTL and testbench
====================================

IMMEDIATE_ENCODER -- requirements
Module: immediate_encoder

Interface
REQ-001 SHALL have port clk, input, 1: the single clock; all state updates on the rising edge.
REQ-002 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-003 SHALL have port in_valid, input, 1: imm_in/imm_src valid this cycle.
REQ-004 SHALL have port in_ready, output, 1: encoder accepts the input this cycle.
REQ-005 SHALL have port imm_in, input, 32: the signed or unsigned immediate to pack.
REQ-006 SHALL have port imm_src, input, 3: the format code (000 I, 001 S, 010 B, 011 U, 100 J, 101 shamt).
REQ-007 SHALL have port out_valid, output, 1: imm_field and imm_err are valid.
REQ-008 SHALL have port out_ready, input, 1: the consumer accepts the output.
REQ-009 SHALL have port imm_field, output, 25: the packed immediate bits, where field[n] is instruction bit n+7 (bits 31:7).
REQ-010 SHALL have port imm_err, output, 1: imm_in is not representable in the selected format.
REQ-011 SHALL have port err_count, output, 8: saturating count of errored outputs that completed the handshake.

Function
REQ-012 SHALL set to zero every field bit not listed for the selected format.
REQ-013 I (000): field[24:13]=imm[11:0]; err unless imm[31:11] are all equal.
REQ-014 S (001): field[24:18]=imm[11:5], field[4:0]=imm[4:0]; err unless imm[31:11] are all equal.
REQ-015 B (010): field[24]=imm[12], field[23:18]=imm[10:5], field[4:1]=imm[4:1], field[0]=imm[11]; err unless imm[31:12] are all equal and imm[0]=0.
REQ-016 U (011): field[24:5]=imm[31:12]; err unless imm[11:0]=0.
REQ-017 J (100): field[24]=imm[20], field[23:14]=imm[10:1], field[13]=imm[11], field[12:5]=imm[19:12]; err unless imm[31:20] are all equal and imm[0]=0.
REQ-018 shamt (101): field[17:13]=imm[4:0]; err unless imm[31:5]=0.
REQ-019 imm_src 110/111: field=0, err=1.
REQ-020 On error, SHALL still output the truncated field per REQ-013..018, with no saturation.
REQ-021 SHALL use a two-stage pipeline: S1 registers imm_in/imm_src, S2 registers field/err; each stage holds a valid bit.
REQ-022 Latency SHALL be 2 cycles from the input handshake to out_valid, with out_ready held high.
REQ-023 Throughput SHALL be one result per cycle while out_ready=1.
REQ-024 S2 SHALL load when S2 is empty or out_ready=1.
REQ-025 S1 SHALL advance when S2 loads.
REQ-026 in_ready SHALL equal !s1_valid || s2_loads, combinational, with no dependency on in_valid.
REQ-027 While out_valid=1 and out_ready=0, imm_field/imm_err SHALL hold stable, and no accepted input SHALL be lost or duplicated.
REQ-028 An input handshake and an output handshake in the same cycle SHALL both complete.
REQ-029 out_valid SHALL equal s2_valid; the output SHALL not depend combinationally on in_valid.
REQ-030 err_count SHALL increment by 1 on each cycle with out_valid & out_ready & imm_err.
REQ-031 err_count SHALL saturate at 255 and never wrap.

Reset
REQ-032 rst=1 SHALL immediately force s1_valid=0, s2_valid=0, out_valid=0, imm_field=0, imm_err=0, err_count=0.
REQ-033 A reset mid-operation SHALL discard all in-flight entries, with no output after deassertion until new inputs arrive.
REQ-034 in_ready SHALL be 1 in the first cycle after rst deasserts.

Verification
REQ-035 I: imm_in=0xFFFFF800, imm_src=000, out_ready=1 -> 2 cycles later imm_field=0x1000000, imm_err=0; imm_in=0x00000800 -> imm_field=0x1000000, imm_err=1.
REQ-036 B: imm_in=0x00000FFE, imm_src=010 -> imm_field=0xFC001F, imm_err=0; imm_in=0x00000FFF -> imm_err=1.
REQ-037 U: imm_in=0x12345001, imm_src=011 -> imm_field=0x2468A0, imm_err=1; shamt imm_in=31, imm_src=101 -> imm_field=0x3E000, imm_err=0.
REQ-038 Backpressure: stream 5 inputs back-to-back with out_ready low for 3 cycles mid-stream -> in_ready drops once both stages are full, the held output is stable, and all 5 results emerge in order with no duplicates.
REQ-039 Reset: assert rst while both stages are valid -> out_valid=0 and err_count=0 immediately, with no stale output afterward.
REQ-040 Saturation: 260 errored outputs with imm_src=111 -> err_count reaches 255 and stays at 255.

Source files
------------

// File: rtl/immediate_encoder_if.sv
// Handshake bundle for the immediate encoder: input stream, output stream
// and the error counter.
interface immediate_encoder_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] imm_in;
  logic [2:0]  imm_src;
  logic        out_valid;
  logic        out_ready;
  logic [24:0] imm_field;
  logic        imm_err;
  logic [7:0]  err_count;

  modport master (
    output in_valid, imm_in, imm_src, out_ready,
    input  in_ready, out_valid, imm_field, imm_err, err_count
  );

  modport slave (
    input  in_valid, imm_in, imm_src, out_ready,
    output in_ready, out_valid, imm_field, imm_err, err_count
  );
endinterface

// File: rtl/immediate_encoder.sv
// Packs an immediate into RISC-V instruction bits 31:7 for the I/S/B/U/J
// and shamt formats, with a representability flag. Two-stage pipeline.
module immediate_encoder (
  input  logic                  clk,
  input  logic                  rst,
  immediate_encoder_if.slave    bus
);

  logic        r_s1_valid;
  logic [31:0] r_s1_imm;
  logic [2:0]  r_s1_src;
  logic        r_s2_valid;
  logic [24:0] r_s2_field;
  logic        r_s2_err;
  logic [7:0]  r_err_cnt;

  logic        w_s2_load;
  logic        w_in_ready;
  logic        w_out_hs;
  logic [24:0] w_field;
  logic        w_err;
  logic        w_sx11;
  logic        w_sx12;
  logic        w_sx20;

  assign w_s2_load  = !r_s2_valid || bus.out_ready;
  assign w_in_ready = !r_s1_valid || w_s2_load;
  assign w_out_hs   = r_s2_valid && bus.out_ready;

  // Upper bits all equal means the value fits as a sign-extended field.
  assign w_sx11 = (&r_s1_imm[31:11]) || !(|r_s1_imm[31:11]);
  assign w_sx12 = (&r_s1_imm[31:12]) || !(|r_s1_imm[31:12]);
  assign w_sx20 = (&r_s1_imm[31:20]) || !(|r_s1_imm[31:20]);

  always_comb begin
    w_field = '0;
    w_err   = 1'b0;
    unique case (r_s1_src)
      3'b000: begin
        w_field[24:13] = r_s1_imm[11:0];
        w_err          = !w_sx11;
      end
      3'b001: begin
        w_field[24:18] = r_s1_imm[11:5];
        w_field[4:0]   = r_s1_imm[4:0];
        w_err          = !w_sx11;
      end
      3'b010: begin
        w_field[24]    = r_s1_imm[12];
        w_field[23:18] = r_s1_imm[10:5];
        w_field[4:1]   = r_s1_imm[4:1];
        w_field[0]     = r_s1_imm[11];
        w_err          = !w_sx12 || r_s1_imm[0];
      end
      3'b011: begin
        w_field[24:5] = r_s1_imm[31:12];
        w_err         = |r_s1_imm[11:0];
      end
      3'b100: begin
        w_field[24]    = r_s1_imm[20];
        w_field[23:14] = r_s1_imm[10:1];
        w_field[13]    = r_s1_imm[11];
        w_field[12:5]  = r_s1_imm[19:12];
        w_err          = !w_sx20 || r_s1_imm[0];
      end
      3'b101: begin
        w_field[17:13] = r_s1_imm[4:0];
        w_err          = |r_s1_imm[31:5];
      end
      default: begin
        w_field = '0;
        w_err   = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_imm   <= '0;
      r_s1_src   <= '0;
    end else if (w_in_ready) begin
      r_s1_valid <= bus.in_valid;
      if (bus.in_valid) begin
        r_s1_imm <= bus.imm_in;
        r_s1_src <= bus.imm_src;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s2_valid <= 1'b0;
      r_s2_field <= '0;
      r_s2_err   <= 1'b0;
    end else if (w_s2_load) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_s2_field <= w_field;
        r_s2_err   <= w_err;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err_cnt <= '0;
    end else if (w_out_hs && r_s2_err && (r_err_cnt != 8'hFF)) begin
      r_err_cnt <= r_err_cnt + 8'd1;
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_s2_valid;
  assign bus.imm_field = r_s2_field;
  assign bus.imm_err   = r_s2_err;
  assign bus.err_count = r_err_cnt;

endmodule

// File: tb/tb_immediate_encoder.sv
// Randomized bench for immediate_encoder with an instruction-level model,
// a per-cycle scoreboard and directed literal cases.
module tb_immediate_encoder;

  logic clk;
  logic rst;
  immediate_encoder_if bus();

  immediate_encoder dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [25:0] q[$];
  int          mcnt;
  logic        held_v;
  logic [25:0] held;
  int          out_hs;

  // Reference: place bits where the ISA puts them in an instruction word,
  // decide representability from the numeric range of the value.
  function automatic logic [25:0] model(logic [31:0] v, logic [2:0] src);
    logic [31:0] ins;
    logic        e;
    int          sv;
    ins = '0;
    e   = 1'b0;
    sv  = int'($signed(v));
    case (src)
      3'd0: begin
        ins[31:20] = v[11:0];
        e = !(sv >= -2048 && sv <= 2047);
      end
      3'd1: begin
        ins[31:25] = v[11:5];
        ins[11:7]  = v[4:0];
        e = !(sv >= -2048 && sv <= 2047);
      end
      3'd2: begin
        ins[31]    = v[12];
        ins[30:25] = v[10:5];
        ins[11:8]  = v[4:1];
        ins[7]     = v[11];
        e = !(sv >= -4096 && sv <= 4095 && (sv % 2) == 0);
      end
      3'd3: begin
        ins[31:12] = v[31:12];
        e = (v % 32'd4096) != 0;
      end
      3'd4: begin
        ins[31]    = v[20];
        ins[30:21] = v[10:1];
        ins[20]    = v[11];
        ins[19:12] = v[19:12];
        e = !(sv >= -(1 << 20) && sv <= (1 << 20) - 1 && (sv % 2) == 0);
      end
      3'd5: begin
        ins[24:20] = v[4:0];
        e = v > 32'd31;
      end
      default: e = 1'b1;
    endcase
    return {e, ins[31:7]};
  endfunction

  task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      mcnt   = 0;
      held_v = 1'b0;
    end else begin
      chk("err_count", {24'd0, bus.err_count}, mcnt);
      if (bus.out_ready && !bus.in_ready)
        chk("in_ready_or", 32'd0, 32'd1);
      if (!bus.in_ready)
        chk("full_when_stall", q.size(), 32'd2);
      if (bus.out_valid) begin
        if (held_v)
          chk("hold_stable", {bus.imm_err, bus.imm_field}, held);
        if (q.size() == 0) begin
          chk("spurious_out", 32'd1, 32'd0);
        end else begin
          chk("result", {bus.imm_err, bus.imm_field}, q[0]);
          if (bus.out_ready) begin
            if (q[0][25] && mcnt < 255) mcnt++;
            void'(q.pop_front());
            out_hs++;
          end
        end
        held_v = !bus.out_ready;
        held   = {bus.imm_err, bus.imm_field};
      end else begin
        held_v = 1'b0;
      end
      if (bus.in_valid && bus.in_ready)
        q.push_back(model(bus.imm_in, bus.imm_src));
    end
  end

  task automatic send(logic [31:0] v, logic [2:0] s);
    logic hs;
    int   n;
    bus.in_valid = 1'b1;
    bus.imm_in   = v;
    bus.imm_src  = s;
    n  = 0;
    hs = 1'b0;
    while (!hs && n < 200) begin
      @(negedge clk);
      hs = bus.in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    if (!hs) chk("send_timeout", 32'd0, 32'd1);
    bus.in_valid = 1'b0;
  endtask

  task automatic latency(logic [31:0] v, logic [2:0] s,
                         logic [24:0] ef, logic ee, string nm);
    bus.out_ready = 1'b1;
    send(v, s);
    chk({nm, "_early"}, {31'd0, bus.out_valid}, 32'd0);
    @(posedge clk);
    #1;
    chk({nm, "_valid"}, {31'd0, bus.out_valid}, 32'd1);
    chk({nm, "_field"}, {7'd0, bus.imm_field}, {7'd0, ef});
    chk({nm, "_err"}, {31'd0, bus.imm_err}, {31'd0, ee});
  endtask

  task automatic drain();
    int n;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    n = 0;
    while (q.size() != 0 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    @(posedge clk);
    #1;
    chk("drain", q.size(), 32'd0);
  endtask

  function automatic logic [31:0] gen_imm();
    int sel;
    sel = $urandom_range(0, 4);
    case (sel)
      0: return $urandom;
      1: return 32'(int'($urandom_range(0, 8191)) - 4096);
      2: return $urandom & 32'hFFFF_F000;
      3: return 32'($urandom_range(0, 63));
      default: return 32'(int'($urandom_range(0, 32'h3F_FFFF)) - 32'h20_0000);
    endcase
  endfunction

  initial begin
    logic hs;
    logic saw_full;
    int   acc;
    int   c;
    int   hs0;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.imm_in    = '0;
    bus.imm_src   = '0;
    bus.out_ready = 1'b0;
    out_hs        = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst_field", {7'd0, bus.imm_field}, 32'd0);
    chk("rst_err", {31'd0, bus.imm_err}, 32'd0);
    chk("rst_count", {24'd0, bus.err_count}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("in_ready_after_rst", {31'd0, bus.in_ready}, 32'd1);
    @(posedge clk);
    #1;

    latency(32'hFFFF_F800, 3'd0, 25'h100_0000, 1'b0, "I_neg");
    latency(32'h0000_0800, 3'd0, 25'h100_0000, 1'b1, "I_ovf");
    latency(32'h0000_0FFE, 3'd2, 25'h0FC_001F, 1'b0, "B_ok");
    latency(32'h0000_0FFF, 3'd2, 25'h0FC_001F, 1'b1, "B_odd");
    latency(32'h1234_5001, 3'd3, 25'h024_68A0, 1'b1, "U_low");
    latency(32'd31, 3'd5, 25'h003_E000, 1'b0, "shamt31");
    latency(32'h0000_0FFE, 3'd6, 25'h0, 1'b1, "src110");
    drain();

    // Random traffic, input held until accepted, random backpressure.
    for (int i = 0; i < 800; i++) begin
      @(negedge clk);
      hs = bus.in_valid && bus.in_ready;
      @(posedge clk);
      #1;
      if (hs || !bus.in_valid) begin
        if ($urandom_range(0, 3) != 0) begin
          bus.in_valid = 1'b1;
          bus.imm_in   = gen_imm();
          bus.imm_src  = 3'($urandom_range(0, 7));
        end else begin
          bus.in_valid = 1'b0;
        end
      end
      bus.out_ready = ($urandom_range(0, 3) != 0);
    end
    drain();

    // Back-to-back stream with a 3-cycle output stall mid-stream.
    hs0      = out_hs;
    saw_full = 1'b0;
    acc      = 0;
    c        = 0;
    bus.in_valid = 1'b1;
    bus.imm_in   = 32'd100;
    bus.imm_src  = 3'd0;
    while (acc < 5 && c < 100) begin
      bus.out_ready = !(c >= 2 && c < 5);
      @(negedge clk);
      if (!bus.in_ready) saw_full = 1'b1;
      hs = bus.in_ready;
      @(posedge clk);
      #1;
      c++;
      if (hs) begin
        acc++;
        bus.imm_in = bus.imm_in + 32'd7;
      end
      if (acc == 5) bus.in_valid = 1'b0;
    end
    chk("bp_accepted", acc, 32'd5);
    chk("bp_saw_full", {31'd0, saw_full}, 32'd1);
    drain();
    chk("bp_outputs", out_hs - hs0, 32'd5);

    // Reset with both stages occupied.
    bus.out_ready = 1'b0;
    send(32'h0000_0800, 3'd0);
    send(32'h0000_0003, 3'd4);
    @(negedge clk);
    chk("pre_rst_full", {31'd0, bus.in_ready}, 32'd0);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("mid_rst_count", {24'd0, bus.err_count}, 32'd0);
    chk("mid_rst_field", {7'd0, bus.imm_field}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("rst2_in_ready", {31'd0, bus.in_ready}, 32'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("no_stale", {31'd0, bus.out_valid}, 32'd0);
    end
    @(posedge clk);
    #1;

    // Saturation of the error counter.
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.imm_src   = 3'd7;
    for (int i = 0; i < 260; i++) begin
      bus.imm_in = $urandom;
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    drain();
    chk("sat_255", {24'd0, bus.err_count}, 32'd255);
    repeat (3) @(posedge clk);
    #1;
    chk("sat_hold", {24'd0, bus.err_count}, 32'd255);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
